// File: rtl/count_seq_checker.sv
// Checks that {Q2,Q1,Q0} steps by +1 (mod 8) each clock; locks after LOCK_CNT good steps.
// Optional macro CHK_DOWN_EN adds a mode input (1=up, 0=down) selecting the count direction.
//
// state | meaning
// IDLE  | capture first sample, no comparison
// ACQ   | counting consecutive matches toward lock
// LOCK  | tracking; mismatches pulse err and count toward unlock
module count_seq_checker #(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_ERR = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Q2,
    input  logic       Q1,
    input  logic       Q0,
`ifdef CHK_DOWN_EN
    input  logic       mode,
`endif
    output logic       locked,
    output logic       err,
    output logic [7:0] err_cnt,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACQ  = 2'b01,
        LOCK = 2'b10
    } state_t;

    state_t     cur, nxt;
    logic [2:0] prev, sample, expected;
    logic [3:0] match_cnt, match_nxt, miss_cnt, miss_nxt;
    logic [7:0] err_cnt_nxt;
    logic       err_nxt, locked_nxt, match, mode_chg;

    assign sample = {Q2, Q1, Q0};

`ifdef CHK_DOWN_EN
    logic mode_q;
    assign expected = mode ? (prev + 3'd1) : (prev - 3'd1);
    assign mode_chg = (mode != mode_q);
`else
    assign expected = prev + 3'd1;
    assign mode_chg = 1'b0;
`endif

    assign match = (sample == expected);

    always_comb begin
        nxt         = cur;
        match_nxt   = match_cnt;
        miss_nxt    = miss_cnt;
        err_nxt     = 1'b0;
        err_cnt_nxt = err_cnt;
        case (cur)
            IDLE: begin
                nxt       = ACQ;
                match_nxt = 4'd0;
                miss_nxt  = 4'd0;
            end
            ACQ: begin
                if (match) begin
                    if (match_cnt + 4'd1 == 4'(LOCK_CNT)) begin
                        nxt       = LOCK;
                        match_nxt = 4'd0;
                        miss_nxt  = 4'd0;
                    end else begin
                        match_nxt = match_cnt + 4'd1;
                    end
                end else begin
                    match_nxt = 4'd0;
                end
            end
            LOCK: begin
                if (match) begin
                    miss_nxt = 4'd0;
                end else begin
                    err_nxt = 1'b1;
                    if (err_cnt != 8'hff)
                        err_cnt_nxt = err_cnt + 8'd1;
                    if (miss_cnt + 4'd1 == 4'(UNLOCK_ERR)) begin
                        nxt       = ACQ;
                        match_nxt = 4'd0;
                        miss_nxt  = 4'd0;
                    end else begin
                        miss_nxt = miss_cnt + 4'd1;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
        // A direction change restarts acquisition silently.
        if (mode_chg) begin
            nxt         = ACQ;
            match_nxt   = 4'd0;
            miss_nxt    = 4'd0;
            err_nxt     = 1'b0;
            err_cnt_nxt = err_cnt;
        end
        locked_nxt = (nxt == LOCK);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur       <= IDLE;
            prev      <= 3'd0;
            match_cnt <= 4'd0;
            miss_cnt  <= 4'd0;
            err       <= 1'b0;
            err_cnt   <= 8'd0;
            locked    <= 1'b0;
`ifdef CHK_DOWN_EN
            mode_q    <= 1'b1;
`endif
        end else begin
            cur       <= nxt;
            prev      <= sample;
            match_cnt <= match_nxt;
            miss_cnt  <= miss_nxt;
            err       <= err_nxt;
            err_cnt   <= err_cnt_nxt;
            locked    <= locked_nxt;
`ifdef CHK_DOWN_EN
            mode_q    <= mode;
`endif
        end
    end

    assign state = cur;

endmodule
